// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared types and sizing for the FIFO stream reader.
//   rd_state_e - framing state (data words vs. appended checksum word)
//   BufDepth   - output buffer entries
//   OccWidth   - width of the buffer occupancy count (0..BufDepth)
//   cnt_width  - width of a counter that holds 0..n-1 (minimum 1 bit)
package fifo_stream_pkg;

    typedef enum logic [0:0] {
        StData,
        StCsum
    } rd_state_e;

    localparam int unsigned BufDepth = 2;
    localparam int unsigned OccWidth = $clog2(BufDepth + 1);

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready stream carrying burst-framed words.
//   valid - word valid (master)
//   ready - consumer accepts when high together with valid (slave)
//   data  - stream word (master)
//   last  - final word of a burst (master)
interface fifo_stream_reader_if #(
    parameter int unsigned DataWidth = 16
);

    logic                 valid;
    logic                 ready;
    logic [DataWidth-1:0] data;
    logic                 last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/stream_out_buf.sv
// stream_out_buf: two-entry in-order buffer feeding the stream output.
//   clk, rst - clock, synchronous active-high reset (clears entries to zero)
//   push_i   - write data_i at the tail this cycle
//   data_i   - word to write
//   pop_i    - drop the head entry this cycle (ignored when empty)
//   head_o   - current head entry
//   occ_o    - number of valid entries (0..2)
// The caller must never push into a full buffer without popping the same cycle.
module stream_out_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] head_o,
    output logic [OccWidth-1:0]  occ_o
);

    logic [DataWidth-1:0] e0_q, e0_d;
    logic [DataWidth-1:0] e1_q, e1_d;
    logic [OccWidth-1:0]  occ_q, occ_d;
    logic                 do_pop;

    assign do_pop = pop_i && (occ_q != '0);

    // Entry 0 is always the head, so a pop shifts entry 1 forward and a push
    // lands in the first slot left free after that shift.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (do_pop) begin
            e0_d  = e1_q;
            occ_d = occ_q - OccWidth'(1);
        end
        if (push_i) begin
            if (occ_d == '0) begin
                e0_d = data_i;
            end else begin
                e1_d = data_i;
            end
            occ_d = occ_d + OccWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head_o = e0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (registered read data, one
// cycle latency) into a burst-framed valid/ready stream at full rate.
//   clk, rst     - single clock, synchronous active-high reset
//   fifo_empty_i - FIFO empty flag
//   fifo_data_i  - FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o - FIFO pop, never asserted while the FIFO is empty
//   busy_o       - buffer non-empty, read in flight or checksum pending
//   m_if         - output stream (master modport)
// Build option: define FIFO_STREAM_CSUM_EN to append an XOR checksum word to
// every burst of BurstLen data words; last then marks the checksum word.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned BurstLen  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty_i,
    input  logic [DataWidth-1:0] fifo_data_i,
    output logic                 fifo_rd_en_o,
    output logic                 busy_o,
    fifo_stream_reader_if.master m_if
);

    localparam int unsigned CntWidth = cnt_width(BurstLen);
    localparam int unsigned CmpWidth = OccWidth + 1;

    logic                 m_valid;
    logic                 m_last;
    logic [DataWidth-1:0] m_data;
    logic                 pop;
    logic                 buf_pop;
    logic [DataWidth-1:0] head;
    logic [OccWidth-1:0]  occ;
    logic                 inflight_q;
    logic [CntWidth-1:0]  wcnt_q, wcnt_d;
    logic                 last_word;
    logic [CmpWidth-1:0]  committed;
    logic                 csum_busy;

    assign pop       = m_valid && m_if.ready;
    assign last_word = (wcnt_q == CntWidth'(BurstLen - 1));

    // A read already in flight will land in the buffer next cycle, so it counts
    // against capacity; a pop this cycle frees a slot in time for it.
    assign committed    = CmpWidth'(occ) + CmpWidth'(inflight_q);
    assign fifo_rd_en_o = !fifo_empty_i && !rst &&
                          (committed < (CmpWidth'(BufDepth) + CmpWidth'(buf_pop)));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            inflight_q <= fifo_rd_en_o;
            wcnt_q     <= wcnt_d;
        end
    end

    // Counts accepted data words only; holds across FIFO underrun gaps.
    always_comb begin
        wcnt_d = wcnt_q;
        if (buf_pop) begin
            wcnt_d = last_word ? '0 : wcnt_q + CntWidth'(1);
        end
    end

    stream_out_buf #(
        .DataWidth (DataWidth)
    ) u_out_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .data_i (fifo_data_i),
        .pop_i  (buf_pop),
        .head_o (head),
        .occ_o  (occ)
    );

`ifdef FIFO_STREAM_CSUM_EN
    rd_state_e            state_q, state_d;
    logic [DataWidth-1:0] csum_q, csum_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StData;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StData: if (buf_pop && last_word) state_d = StCsum;
            StCsum: if (pop) state_d = StData;
            default: state_d = StData;
        endcase
    end

    // While the checksum word is presented the buffer head is held, but reads
    // keep filling the buffer up to capacity.
    always_comb begin
        m_valid   = 1'b0;
        m_data    = head;
        m_last    = 1'b0;
        buf_pop   = 1'b0;
        csum_busy = 1'b0;
        unique case (state_q)
            StData: begin
                m_valid = (occ != '0);
                buf_pop = pop;
            end
            StCsum: begin
                m_valid   = 1'b1;
                m_data    = csum_q;
                m_last    = 1'b1;
                csum_busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        csum_d = csum_q;
        if ((state_q == StCsum) && pop) begin
            csum_d = '0;
        end else if (buf_pop) begin
            csum_d = csum_q ^ head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign m_valid   = (occ != '0);
    assign m_data    = head;
    assign m_last    = m_valid && last_word;
    assign buf_pop   = pop;
    assign csum_busy = 1'b0;
`endif

    assign m_if.valid = m_valid;
    assign m_if.data  = m_data;
    assign m_if.last  = m_last;
    assign busy_o     = (occ != '0) || inflight_q || csum_busy;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed self-checking bench for fifo_stream_reader.
// Models the upstream FIFO as a word array with registered read data and acts
// as the stream consumer. With FIFO_STREAM_CSUM_EN defined the checksum
// scenario replaces the plain-framing scenarios.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [15:0] fifo_data = '0;
    logic        fifo_rd_en;
    logic        busy;

    logic [15:0] fmem [0:255];
    int          wp = 0;
    int          rp = 0;
    logic        underflow = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_stream_reader_if #(.DataWidth(16)) m_if ();

    fifo_stream_reader #(
        .DataWidth (16),
        .BurstLen  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rd_en_o (fifo_rd_en),
        .busy_o       (busy),
        .m_if         (m_if)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) underflow <= 1'b1;
            fifo_data <= fmem[rp];
            rp <= rp + 1;
        end
    end

    // Advance to the next cycle and settle inputs away from the clock edge.
    task automatic next_cycle(input logic rdy);
        @(negedge clk);
        m_if.ready = rdy;
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        fmem[wp] = w;
        wp = wp + 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m_if.ready = 1'b0;
        next_cycle(1'b0);
        next_cycle(1'b0);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_if.valid); end
        checks++; if (m_if.data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", m_if.data); end
        checks++; if (m_if.last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", m_if.last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        next_cycle(1'b1);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL basic_idle_rd got %b want 0", fifo_rd_en); end
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL basic_rd_same_cycle got %b want 1", fifo_rd_en); end
        next_cycle(1'b1);
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n1 got %b want 0", m_if.valid); end
        for (int k = 0; k < 4; k++) begin
            next_cycle(1'b1);
            checks++; if (m_if.valid !== 1'b1 || m_if.data !== 16'(k + 1))
                begin errors++; $display("FAIL basic_word%0d got v=%b d=%h want v=1 d=%h", k, m_if.valid, m_if.data, 16'(k + 1)); end
            checks++; if (m_if.last !== (k == 3))
                begin errors++; $display("FAIL basic_last%0d got %b want %b", k, m_if.last, (k == 3)); end
        end
        next_cycle(1'b1);
        checks++; if (m_if.valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL basic_drained got v=%b busy=%b want 0 0", m_if.valid, busy); end
    endtask

    task automatic test_backpressure;
        int nrd;
        int n;
        int cyc;
        logic unstable;
        next_cycle(1'b0);
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        #1;
        nrd = 0;
        unstable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle(1'b0);
            if (fifo_rd_en === 1'b1) nrd++;
            if (m_if.valid === 1'b1 && m_if.data !== 16'h0001) unstable = 1'b1;
        end
        checks++; if (nrd != 2) begin errors++; $display("FAIL bp_reads got %0d want 2", nrd); end
        checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL bp_head_stable got unstable want stable"); end
        checks++; if (m_if.valid !== 1'b1 || m_if.data !== 16'h0001)
            begin errors++; $display("FAIL bp_head got v=%b d=%h want v=1 d=0001", m_if.valid, m_if.data); end
        n = 0;
        cyc = 0;
        while (n < 8 && cyc < 20) begin
            next_cycle(1'b1);
            cyc++;
            if (m_if.valid === 1'b1) begin
                checks++; if (m_if.data !== 16'(n + 1) || m_if.last !== (n == 3 || n == 7))
                    begin errors++; $display("FAIL bp_word%0d got d=%h l=%b want d=%h l=%b", n, m_if.data, m_if.last, 16'(n + 1), (n == 3 || n == 7)); end
                n++;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL bp_count got %0d want 8", n); end
        checks++; if (cyc != 8) begin errors++; $display("FAIL bp_rate got %0d cycles want 8", cyc); end
    endtask

    task automatic test_toggle;
        int n;
        int cyc;
        logic hold;
        logic [15:0] held;
        logic rdy;
        next_cycle(1'b1);
        for (int i = 1; i <= 12; i++) push_word(16'h0A00 + 16'(i));
        n = 0;
        cyc = 0;
        hold = 1'b0;
        held = '0;
        while (n < 12 && cyc < 60) begin
            rdy = (cyc % 2 == 0);
            next_cycle(rdy);
            cyc++;
            if (hold) begin
                checks++; if (m_if.valid !== 1'b1 || m_if.data !== held)
                    begin errors++; $display("FAIL tog_hold got v=%b d=%h want v=1 d=%h", m_if.valid, m_if.data, held); end
            end
            hold = (m_if.valid === 1'b1) && !rdy;
            held = m_if.data;
            if (m_if.valid === 1'b1 && rdy) begin
                checks++; if (m_if.data !== 16'h0A00 + 16'(n + 1) || m_if.last !== (n % 4 == 3))
                    begin errors++; $display("FAIL tog_word%0d got d=%h l=%b want d=%h l=%b", n, m_if.data, m_if.last, 16'h0A00 + 16'(n + 1), (n % 4 == 3)); end
                n++;
            end
        end
        checks++; if (n != 12) begin errors++; $display("FAIL tog_count got %0d want 12", n); end
    endtask

    task automatic test_reset_mid;
        int n;
        int cyc;
        next_cycle(1'b1);
        for (int i = 1; i <= 8; i++) push_word(16'h0B00 + 16'(i));
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 10) begin
            next_cycle(1'b1);
            cyc++;
            if (m_if.valid === 1'b1) n++;
        end
        next_cycle(1'b0);
        rst = 1'b1;
        wp = rp;
        next_cycle(1'b0);
        checks++; if (fifo_rd_en !== 1'b0 || m_if.valid !== 1'b0 || m_if.data !== 16'h0000 ||
                      m_if.last !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs got rd=%b v=%b d=%h l=%b busy=%b want all 0",
                                     fifo_rd_en, m_if.valid, m_if.data, m_if.last, busy); end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(16'h0C00 + 16'(i));
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 20) begin
            next_cycle(1'b1);
            cyc++;
            if (m_if.valid === 1'b1) begin
                checks++; if (m_if.data !== 16'h0C00 + 16'(n + 1) || m_if.last !== (n == 3))
                    begin errors++; $display("FAIL rstmid_word%0d got d=%h l=%b want d=%h l=%b", n, m_if.data, m_if.last, 16'h0C00 + 16'(n + 1), (n == 3)); end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rstmid_count got %0d want 4", n); end
    endtask

    task automatic test_empty_gap;
        int n;
        int cyc;
        logic gap_bad;
        next_cycle(1'b1);
        push_word(16'h0D01);
        push_word(16'h0D02);
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 10) begin
            next_cycle(1'b1);
            cyc++;
            if (m_if.valid === 1'b1) begin
                checks++; if (m_if.data !== 16'h0D01 + 16'(n) || m_if.last !== 1'b0)
                    begin errors++; $display("FAIL gap_word%0d got d=%h l=%b want d=%h l=0", n, m_if.data, m_if.last, 16'h0D01 + 16'(n)); end
                n++;
            end
        end
        gap_bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            next_cycle(1'b1);
            if (m_if.valid !== 1'b0) gap_bad = 1'b1;
        end
        checks++; if (gap_bad !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL gap_idle got valid-seen=%b busy=%b want 0 0", gap_bad, busy); end
        push_word(16'h0D03);
        push_word(16'h0D04);
        cyc = 0;
        while (n < 4 && cyc < 10) begin
            next_cycle(1'b1);
            cyc++;
            if (m_if.valid === 1'b1) begin
                checks++; if (m_if.data !== 16'h0D01 + 16'(n) || m_if.last !== (n == 3))
                    begin errors++; $display("FAIL gap_word%0d got d=%h l=%b want d=%h l=%b", n, m_if.data, m_if.last, 16'h0D01 + 16'(n), (n == 3)); end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL gap_count got %0d want 4", n); end
    endtask

    task automatic test_csum;
        logic [15:0] exp_d [10];
        int n;
        int cyc;
        exp_d = '{16'h00F0, 16'h0F00, 16'h1234, 16'h0001, 16'h1DC5,
                  16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004};
        next_cycle(1'b1);
        push_word(16'h00F0);
        push_word(16'h0F00);
        push_word(16'h1234);
        push_word(16'h0001);
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 40) begin
            next_cycle(1'b1);
            cyc++;
            if (m_if.valid === 1'b1) begin
                checks++; if (m_if.data !== exp_d[n] || m_if.last !== (n == 4 || n == 9))
                    begin errors++; $display("FAIL csum_word%0d got d=%h l=%b want d=%h l=%b", n, m_if.data, m_if.last, exp_d[n], (n == 4 || n == 9)); end
                n++;
            end
        end
        checks++; if (n != 10) begin errors++; $display("FAIL csum_count got %0d want 10", n); end
    endtask

    task automatic test_no_underflow;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rd_while_empty got %b want 0", underflow); end
    endtask

    initial begin
        m_if.ready = 1'b0;
        test_reset();
`ifdef FIFO_STREAM_CSUM_EN
        test_csum();
`else
        test_basic();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        test_empty_gap();
`endif
        test_no_underflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
